pc_jump_ctrl: RTL and testbench
===============================

# pc_jump_ctrl

Parametrised program-counter and jump-control block for the Hack-style CPU. It evaluates the 3-bit jump field against the ALU zero/negative flags, as the existing combinational `load` unit does. It also owns the program-counter register, stall handling and halt-loop detection, and optionally collects branch statistics. The block sits between the instruction decoder/ALU and instruction memory, and drives the fetch address every cycle.

## Interface
- `ADDR_W`, 15: program-counter and target width in bits.
- `STAT_W`, 16: width of each statistics counter (used only when statistics are compiled in).
- `RESET_PC`, 0: value loaded into `pc` on reset.

- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `en`, input, 1: advance enable. 0 means stall, and all state holds.
- `is_c`, input, 1: the current instruction is a C-instruction, so `j` is valid.
- `j`, input, 3: jump field. `j[2]`=JLT, `j[1]`=JEQ, `j[0]`=JGT.
- `zr`, input, 1: ALU output is zero, for the current instruction.
- `ng`, input, 1: ALU output is negative, for the current instruction.
- `target`, input, ADDR_W: jump destination (A register, low bits).
- `pc`, output, ADDR_W: registered fetch address.
- `taken`, output, 1: registered one-cycle pulse meaning the previous advance was a taken jump.
- `halted`, output, 1: registered flag meaning a self-loop was detected and the PC is frozen.
- `taken_cnt`, output, STAT_W: count of taken jumps. Present only with `PC_JUMP_STATS_EN`.
- `nt_cnt`, output, STAT_W: count of not-taken C-jumps with `j!=0`. Present only with `PC_JUMP_STATS_EN`.

## Operation
- Jump condition `cond = (j[2]&ng) | (j[1]&zr) | (j[0]&~zr&~ng)`.
  - `j=3'b111` is always true.
  - `j=3'b000` is never true.
  - The illegal flag combination `zr=ng=1` is evaluated by the formula as-is, with no special casing.
- `jump = en & is_c & cond & ~halted`.
- State machine `RUN` / `HALTED`:
  - RUN → HALTED when `jump` is asserted and `target==pc` (the Hack `@END; 0;JMP` idiom).
  - HALTED is left only by `reset`.
  - In HALTED, `pc` holds, `taken`=0, and the counters hold.
- PC update in RUN when `en`=1:
  - If `jump`, `pc<=target`.
  - Otherwise `pc<=pc+1`, modulo 2^ADDR_W. `2^ADDR_W-1` wraps to 0.
- When `en`=0, `pc`, `taken`, state and counters all hold. `taken` is *not* cleared during a stall; it keeps its last value until the next advance.
- `taken<=jump` on each advance. The self-loop jump that enters HALTED also sets `taken`=1 for that one cycle.

## Timing
- Reset (synchronous, dominates all inputs): `pc=RESET_PC`, `taken=0`, `halted=0`, state=RUN, counters=0.
- `reset` asserted in the same cycle as a jump or halt condition: reset wins.
- Latency: flags and `j` are sampled at edge N, and `pc` and `taken` reflect them after edge N. The decision is single-cycle, with no pipeline bubble.
- `cond` is combinational from `j`, `zr`, `ng`. There is no path from `pc` to `cond`.
- The halt comparison uses the `pc` value before the update, i.e. the address of the jump instruction itself.
- Counters saturate at `2^STAT_W-1` and do not wrap.

## Configuration
- `PC_JUMP_STATS_EN` defined:
  - `taken_cnt` and `nt_cnt` exist.
  - `taken_cnt` increments on each `jump`.
  - `nt_cnt` increments on each `en & is_c & (j!=0) & ~cond` in RUN.
- `PC_JUMP_STATS_EN` undefined: neither the ports nor the logic exist. All other behaviour is identical.

## Structure
- Shared package `hack_cpu_pkg` holds:
  - `JMP_NULL..JMP_JMP` 3-bit encodings (`JGT=3'b001`, `JEQ=3'b010`, `JGE=3'b011`, `JLT=3'b100`, `JNE=3'b101`, `JLE=3'b110`, `JMP=3'b111`).
  - The `pc_state_t` enum {RUN, HALTED}.
- Sub-module `jump_cond`: combinational `cond` from `j`, `zr`, `ng`. It is a generalised drop-in for the existing `load` unit, and is instantiated once.

## Test plan
- Condition sweep: all 8 `j` × {`zr`,`ng`} ∈ {00,01,10}, with `is_c=1`, `en=1`, `target=15'h0100`, `pc=15'h0010`. Then `pc=0x0100` and `taken=1` exactly where `cond` is true, otherwise `pc=0x0011` and `taken=0`.
- Reset: assert `reset` mid-run at `pc=0x0123` with a taken jump in the same cycle. The next cycle shows `pc=0`, `taken=0`, `halted=0`.
- Stall: `en=0` for 3 cycles while `j=JMP`, `is_c=1`. Then `pc` and `taken` are unchanged, and the jump occurs on the first cycle with `en=1`.
- Wrap: with `ADDR_W=4`, `pc=4'hF`, no jump. The next cycle shows `pc=0`.
- Halt: at `pc=0x0200`, apply `j=JMP` with `target=0x0200`. Then `halted=1`, `taken` pulses once, and `pc` stays `0x0200` for 10 cycles of any further jumps. Only `reset` clears it.
- Stats (with `PC_JUMP_STATS_EN`, `STAT_W=2`): 5 taken jumps give `taken_cnt=3` (saturated). 2 JEQ with `zr=0` give `nt_cnt=2`.

Source files
------------

// File: rtl/hack_cpu_pkg.sv
// Shared Hack CPU encodings: jump-field values and PC controller state.
package hack_cpu_pkg;

    localparam logic [2:0] JMP_NULL = 3'b000;
    localparam logic [2:0] JMP_JGT  = 3'b001;
    localparam logic [2:0] JMP_JEQ  = 3'b010;
    localparam logic [2:0] JMP_JGE  = 3'b011;
    localparam logic [2:0] JMP_JLT  = 3'b100;
    localparam logic [2:0] JMP_JNE  = 3'b101;
    localparam logic [2:0] JMP_JLE  = 3'b110;
    localparam logic [2:0] JMP_JMP  = 3'b111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } pc_state_t;

endpackage

// File: rtl/jump_cond.sv
// Jump condition from j[2:0]=(JLT,JEQ,JGT) and ALU flags; purely combinational.
// zr=ng=1 is not special-cased, so every set j bit matching a flag fires.
module jump_cond (
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       cond
);

    assign cond = (j[2] & ng) | (j[1] & zr) | (j[0] & ~zr & ~ng);

endmodule

// File: rtl/pc_jump_ctrl.sv
// PC register with single-cycle jump decision and self-loop halt; en=0 stalls all state.
// PC_JUMP_STATS_EN adds saturating taken / not-taken jump counters.
module pc_jump_ctrl
    import hack_cpu_pkg::*;
#(
    parameter int              ADDR_W   = 15,
    parameter int              STAT_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              is_c,
    input  logic [2:0]        j,
    input  logic              zr,
    input  logic              ng,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
`ifdef PC_JUMP_STATS_EN
    output logic [STAT_W-1:0] taken_cnt,
    output logic [STAT_W-1:0] nt_cnt,
`endif
    output logic              halted
);

    pc_state_t state;
    logic      cond;
    logic      running;
    logic      jump;

    jump_cond u_jump_cond (
        .j    (j),
        .zr   (zr),
        .ng   (ng),
        .cond (cond)
    );

    assign running = (state == RUN);
    assign jump    = en & is_c & cond & running;
    assign halted  = (state == HALTED);

    // The halt test compares against the pre-update pc: the jump's own address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            taken <= 1'b0;
        end else if (en) begin
            taken <= jump;
            if (running) begin
                pc <= jump ? target : pc + ADDR_W'(1);
                if (jump && (target == pc))
                    state <= HALTED;
            end
        end
    end

`ifdef PC_JUMP_STATS_EN
    logic not_taken;

    assign not_taken = en & is_c & (j != JMP_NULL) & ~cond & running;

    always_ff @(posedge clk) begin
        if (reset) begin
            taken_cnt <= '0;
            nt_cnt    <= '0;
        end else begin
            if (jump && (taken_cnt != {STAT_W{1'b1}}))
                taken_cnt <= taken_cnt + STAT_W'(1);
            if (not_taken && (nt_cnt != {STAT_W{1'b1}}))
                nt_cnt <= nt_cnt + STAT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Directed bench for pc_jump_ctrl: condition sweep, reset, stall, halt, wrap, optional stats.
module tb_pc_jump_ctrl;
    import hack_cpu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, is_c, zr, ng;
    logic [2:0]  j;
    logic [14:0] target;
    logic [14:0] pc;
    logic        taken, halted;
    logic [1:0]  taken_cnt, nt_cnt;

    logic        w_reset, w_en, w_is_c, w_zr, w_ng;
    logic [2:0]  w_j;
    logic [3:0]  w_target;
    logic [3:0]  w_pc;
    logic        w_taken, w_halted;
    logic [1:0]  w_taken_cnt, w_nt_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    pc_jump_ctrl #(.ADDR_W(15), .STAT_W(2), .RESET_PC(15'h0)) dut (
        .clk(clk), .reset(reset), .en(en), .is_c(is_c), .j(j), .zr(zr), .ng(ng),
        .target(target), .pc(pc), .taken(taken),
`ifdef PC_JUMP_STATS_EN
        .taken_cnt(taken_cnt), .nt_cnt(nt_cnt),
`endif
        .halted(halted)
    );

    pc_jump_ctrl #(.ADDR_W(4), .STAT_W(2), .RESET_PC(4'h0)) dut_w (
        .clk(clk), .reset(w_reset), .en(w_en), .is_c(w_is_c), .j(w_j), .zr(w_zr), .ng(w_ng),
        .target(w_target), .pc(w_pc), .taken(w_taken),
`ifdef PC_JUMP_STATS_EN
        .taken_cnt(w_taken_cnt), .nt_cnt(w_nt_cnt),
`endif
        .halted(w_halted)
    );

`ifndef PC_JUMP_STATS_EN
    assign taken_cnt   = '0;
    assign nt_cnt      = '0;
    assign w_taken_cnt = '0;
    assign w_nt_cnt    = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic c, input logic [2:0] jj,
                         input logic z, input logic n, input logic [14:0] t);
        en = e; is_c = c; j = jj; zr = z; ng = n; target = t;
    endtask

    task automatic jmp_to(input logic [14:0] t);
        drive(1'b1, 1'b1, JMP_JMP, 1'b0, 1'b0, t);
        step();
    endtask

    // Which j values fire for positive / negative / zero flags (bit i = j value i).
    logic [7:0] mask_pos = 8'hAA;
    logic [7:0] mask_neg = 8'hF0;
    logic [7:0] mask_zer = 8'hCC;

    initial begin
        logic [7:0] mask;
        logic       exp;
        reset = 1'b1; drive(1'b0, 1'b0, JMP_NULL, 1'b0, 1'b0, 15'h0);
        w_reset = 1'b1; w_en = 1'b0; w_is_c = 1'b1; w_j = JMP_NULL;
        w_zr = 1'b0; w_ng = 1'b0; w_target = 4'h0;
        step(); step();
        reset = 1'b0; w_reset = 1'b0;

        check("rst_pc", 32'(pc), 32'h0);
        check("rst_taken", 32'(taken), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
`ifdef PC_JUMP_STATS_EN
        check("rst_taken_cnt", 32'(taken_cnt), 32'h0);
        check("rst_nt_cnt", 32'(nt_cnt), 32'h0);
`endif

        for (int jv = 0; jv < 8; jv++) begin
            for (int f = 0; f < 3; f++) begin
                jmp_to(15'h0010);
                mask = (f == 0) ? mask_pos : (f == 1) ? mask_neg : mask_zer;
                exp  = mask[jv];
                drive(1'b1, 1'b1, 3'(jv), f == 2, f == 1, 15'h0100);
                step();
                check($sformatf("sweep_pc j=%0d f=%0d", jv, f), 32'(pc),
                      exp ? 32'h0100 : 32'h0011);
                check($sformatf("sweep_taken j=%0d f=%0d", jv, f), 32'(taken), 32'(exp));
            end
        end

        // A-instruction: j ignored.
        jmp_to(15'h0010);
        drive(1'b1, 1'b0, JMP_JMP, 1'b0, 1'b0, 15'h0100);
        step();
        check("a_instr_pc", 32'(pc), 32'h0011);
        check("a_instr_taken", 32'(taken), 32'h0);

        jmp_to(15'h0123);
        check("pre_rst_pc", 32'(pc), 32'h0123);
        reset = 1'b1;
        drive(1'b1, 1'b1, JMP_JMP, 1'b0, 1'b0, 15'h0050);
        step();
        reset = 1'b0;
        check("midrst_pc", 32'(pc), 32'h0);
        check("midrst_taken", 32'(taken), 32'h0);
        check("midrst_halted", 32'(halted), 32'h0);

        jmp_to(15'h0040);
        drive(1'b0, 1'b1, JMP_JMP, 1'b0, 1'b0, 15'h0080);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_pc %0d", k), 32'(pc), 32'h0040);
            check($sformatf("stall_taken %0d", k), 32'(taken), 32'h1);
        end
        en = 1'b1;
        step();
        check("unstall_pc", 32'(pc), 32'h0080);
        check("unstall_taken", 32'(taken), 32'h1);
        drive(1'b1, 1'b1, JMP_NULL, 1'b0, 1'b0, 15'h0);
        step();
        check("after_stall_pc", 32'(pc), 32'h0081);
        check("after_stall_taken", 32'(taken), 32'h0);

        jmp_to(15'h0200);
        jmp_to(15'h0200);
        check("halt_pc", 32'(pc), 32'h0200);
        check("halt_taken", 32'(taken), 32'h1);
        check("halt_halted", 32'(halted), 32'h1);
        drive(1'b1, 1'b1, JMP_JMP, 1'b0, 1'b0, 15'h0333);
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("halted_pc %0d", k), 32'(pc), 32'h0200);
            check($sformatf("halted_taken %0d", k), 32'(taken), 32'h0);
            check($sformatf("halted_flag %0d", k), 32'(halted), 32'h1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("unhalt_halted", 32'(halted), 32'h0);
        check("unhalt_pc", 32'(pc), 32'h0);

`ifdef PC_JUMP_STATS_EN
        check("stat_rst_taken_cnt", 32'(taken_cnt), 32'h0);
        for (int k = 1; k <= 5; k++)
            jmp_to(15'(k));
        check("stat_taken_sat", 32'(taken_cnt), 32'h3);
        check("stat_nt_zero", 32'(nt_cnt), 32'h0);
        drive(1'b1, 1'b1, JMP_JEQ, 1'b0, 1'b0, 15'h0);
        step(); step();
        check("stat_nt_2", 32'(nt_cnt), 32'h2);
        check("stat_taken_hold", 32'(taken_cnt), 32'h3);
        step(); step();
        check("stat_nt_sat", 32'(nt_cnt), 32'h3);
`endif

        w_en = 1'b1; w_j = JMP_JMP; w_target = 4'hF;
        step();
        check("wrap_pre_pc", 32'(w_pc), 32'hF);
        w_j = JMP_NULL;
        step();
        check("wrap_pc", 32'(w_pc), 32'h0);
        check("wrap_taken", 32'(w_taken), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
